// File: rtl/ag_tcu_seq_pkg.sv
// Shared types and elaboration helpers for the sequenced tensor-core tile block.
package ag_tcu_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } tcu_state_e;

  // Number of issue beats needed to cover the tile with the given lane count.
  function automatic int tcu_beats(input int tile_m, input int tile_n, input int lanes);
    return (tile_m * tile_n) / lanes;
  endfunction

  // Element index width; never narrower than one bit.
  function automatic int tcu_idx_w(input int tile_m, input int tile_n);
    return (tile_m * tile_n > 1) ? $clog2(tile_m * tile_n) : 1;
  endfunction

  // Width of a counter that must hold values 0..max_val.
  function automatic int tcu_cnt_w(input int max_val);
    return (max_val > 1) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/ag_tcu_dot_lane.sv
// One dot-product lane: d = c + sum_k a[k]*b[k] (signed, wrapping), followed by a
// LANE_LAT-deep register pipe that carries valid and element index alongside the result.
module ag_tcu_dot_lane
  import ag_tcu_seq_pkg::*;
#(
  parameter int TILE_K   = 4,
  parameter int IN_W     = 8,
  parameter int ACC_W    = 32,
  parameter int LANE_LAT = 3,
  parameter int IDX_W    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid_i,
  input  logic [IDX_W-1:0]       idx_i,
  input  logic [TILE_K*IN_W-1:0] a_i,
  input  logic [TILE_K*IN_W-1:0] b_i,
  input  logic [ACC_W-1:0]       c_i,
  output logic                   valid_o,
  output logic [IDX_W-1:0]       idx_o,
  output logic [ACC_W-1:0]       d_o
);

  logic signed [2*IN_W-1:0] prod_s [TILE_K];
  logic        [ACC_W-1:0]  sum_s;

  logic                     valid_q [LANE_LAT];
  logic        [IDX_W-1:0]  idx_q   [LANE_LAT];
  logic        [ACC_W-1:0]  d_q     [LANE_LAT];

  // Full-precision products, sign-extended and summed modulo 2^ACC_W.
  always_comb begin
    sum_s = c_i;
    for (int k = 0; k < TILE_K; k++) begin
      prod_s[k] = (2*IN_W)'(signed'(a_i[k*IN_W +: IN_W])) *
                  (2*IN_W)'(signed'(b_i[k*IN_W +: IN_W]));
      sum_s     = sum_s + ACC_W'(prod_s[k]);
    end
  end

  // Result pipe; clearing valid on reset drops any in-flight write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < LANE_LAT; s++) begin
        valid_q[s] <= 1'b0;
        idx_q[s]   <= '0;
        d_q[s]     <= '0;
      end
    end else begin
      valid_q[0] <= valid_i;
      idx_q[0]   <= idx_i;
      d_q[0]     <= sum_s;
      for (int s = 1; s < LANE_LAT; s++) begin
        valid_q[s] <= valid_q[s-1];
        idx_q[s]   <= idx_q[s-1];
        d_q[s]     <= d_q[s-1];
      end
    end
  end

  assign valid_o = valid_q[LANE_LAT-1];
  assign idx_o   = idx_q[LANE_LAT-1];
  assign d_o     = d_q[LANE_LAT-1];

endmodule

// File: rtl/ag_tcu_tile_seq.sv
// Tile executor D = C + A*B^T: NUM_LANES dot-product lanes are time-multiplexed over
// the tile elements, with optional chaining of the previous result as C.
module ag_tcu_tile_seq
  import ag_tcu_seq_pkg::*;
#(
  parameter int TILE_M    = 4,
  parameter int TILE_N    = 4,
  parameter int TILE_K    = 4,
  parameter int NUM_LANES = 4,
  parameter int IN_W      = 8,
  parameter int ACC_W     = 32,
  parameter int LANE_LAT  = 3,
  parameter int MDATA_W   = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [TILE_M*TILE_K*IN_W-1:0]   in_a,
  input  logic [TILE_N*TILE_K*IN_W-1:0]   in_b,
  input  logic [TILE_M*TILE_N*ACC_W-1:0]  in_c,
  input  logic                            in_chain,
  input  logic [MDATA_W-1:0]              in_mdata,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [TILE_M*TILE_N*ACC_W-1:0]  out_d,
  output logic [MDATA_W-1:0]              out_mdata,
  output logic                            busy
);

  localparam int ELEMS  = TILE_M * TILE_N;
  localparam int BEATS  = tcu_beats(TILE_M, TILE_N, NUM_LANES);
  localparam int IDX_W  = tcu_idx_w(TILE_M, TILE_N);
  localparam int BEAT_W = tcu_cnt_w(BEATS - 1);
  localparam int CNT_W  = tcu_cnt_w(LANE_LAT);

  if ((ELEMS % NUM_LANES) != 0) begin : g_bad_lanes
    $error("ag_tcu_tile_seq: NUM_LANES must divide TILE_M*TILE_N");
  end
  if (LANE_LAT < 1) begin : g_bad_lat
    $error("ag_tcu_tile_seq: LANE_LAT must be at least 1");
  end

  tcu_state_e                   state_q, state_d;
  logic [BEAT_W-1:0]            beat_q, beat_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;

  logic [TILE_M*TILE_K*IN_W-1:0]  a_q;
  logic [TILE_N*TILE_K*IN_W-1:0]  b_q;
  logic [ELEMS*ACC_W-1:0]         c_q;
  logic [ELEMS*ACC_W-1:0]         res_q;
  logic [MDATA_W-1:0]             mdata_q;

  logic accept_s;
  logic out_fire_s;
  logic issue_s;

  logic             lane_valid_s [NUM_LANES];
  logic [IDX_W-1:0] lane_idx_s   [NUM_LANES];
  logic [ACC_W-1:0] lane_d_s     [NUM_LANES];

  // DONE with a ready consumer can take the next op in the same cycle.
  assign in_ready   = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
  assign accept_s   = in_valid & in_ready;
  assign out_fire_s = (state_q == ST_DONE) & out_ready;

  // FSM state, beat and drain counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_ISSUE;
          beat_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (beat_q == BEAT_W'(BEATS - 1)) begin
          state_d = ST_DRAIN;
          cnt_d   = CNT_W'(LANE_LAT);
        end else begin
          beat_d  = beat_q + BEAT_W'(1);
        end
      end
      ST_DRAIN: begin
        // The final lane write lands on the edge where the counter hits zero.
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (out_fire_s && in_valid) begin
          state_d = ST_ISSUE;
          beat_d  = '0;
        end else if (out_fire_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        beat_d  = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    out_valid = 1'b0;
    busy      = 1'b1;
    issue_s   = 1'b0;
    case (state_q)
      ST_IDLE:  busy      = 1'b0;
      ST_ISSUE: issue_s   = 1'b1;
      ST_DRAIN: issue_s   = 1'b0;
      ST_DONE:  out_valid = 1'b1;
      default:  busy      = 1'b0;
    endcase
  end

  // Operand capture; a chained op snapshots the result buffer as its C.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      mdata_q <= '0;
    end else if (accept_s) begin
      a_q     <= in_a;
      b_q     <= in_b;
      c_q     <= in_chain ? res_q : in_c;
      mdata_q <= in_mdata;
    end else begin
      a_q     <= a_q;
      b_q     <= b_q;
      c_q     <= c_q;
      mdata_q <= mdata_q;
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    int                     e_s, row_s, col_s;
    logic [IDX_W-1:0]       idx_s;
    logic [TILE_K*IN_W-1:0] a_row_s, b_col_s;
    logic [ACC_W-1:0]       c_s;

    // Map this lane's beat slot to a tile element and pick its operands.
    always_comb begin
      e_s     = int'(beat_q) * NUM_LANES + l;
      row_s   = e_s / TILE_N;
      col_s   = e_s % TILE_N;
      idx_s   = IDX_W'(e_s);
      a_row_s = a_q[row_s*TILE_K*IN_W +: TILE_K*IN_W];
      b_col_s = b_q[col_s*TILE_K*IN_W +: TILE_K*IN_W];
      c_s     = c_q[e_s*ACC_W +: ACC_W];
    end

    ag_tcu_dot_lane #(
      .TILE_K   (TILE_K),
      .IN_W     (IN_W),
      .ACC_W    (ACC_W),
      .LANE_LAT (LANE_LAT),
      .IDX_W    (IDX_W)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .valid_i (issue_s),
      .idx_i   (idx_s),
      .a_i     (a_row_s),
      .b_i     (b_col_s),
      .c_i     (c_s),
      .valid_o (lane_valid_s[l]),
      .idx_o   (lane_idx_s[l]),
      .d_o     (lane_d_s[l])
    );
  end

  // Result buffer: written only by lane outputs, held across out_fire for chaining.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_q <= '0;
    end else begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (lane_valid_s[l]) begin
          res_q[int'(lane_idx_s[l])*ACC_W +: ACC_W] <= lane_d_s[l];
        end
      end
    end
  end

  assign out_d     = res_q;
  assign out_mdata = mdata_q;

endmodule

// File: tb/tb_ag_tcu_tile_seq.sv
// Directed bench: default-size tile (4 lanes, 32-bit acc) plus a 2-lane 16-bit-acc copy
// for wrap-around and lane-count scaling.
module tb_ag_tcu_tile_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Default instance
  logic         in_valid, in_ready, in_chain, out_valid, out_ready, busy;
  logic [127:0] in_a, in_b;
  logic [511:0] in_c, out_d;
  logic [15:0]  in_mdata, out_mdata;

  // 2-lane, ACC_W=16 instance
  logic         w_in_valid, w_in_ready, w_in_chain, w_out_valid, w_out_ready, w_busy;
  logic [127:0] w_in_a, w_in_b;
  logic [255:0] w_in_c, w_out_d;
  logic [15:0]  w_in_mdata, w_out_mdata;

  int n_cmp = 0;
  int n_bad = 0;

  ag_tcu_tile_seq dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_chain(in_chain), .in_mdata(in_mdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_d(out_d),
    .out_mdata(out_mdata), .busy(busy)
  );

  ag_tcu_tile_seq #(.NUM_LANES(2), .ACC_W(16)) dut_w (
    .clk(clk), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_a(w_in_a), .in_b(w_in_b), .in_c(w_in_c), .in_chain(w_in_chain),
    .in_mdata(w_in_mdata), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_d(w_out_d), .out_mdata(w_out_mdata), .busy(w_busy)
  );

  function automatic logic [127:0] fill8(input logic [7:0] v);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = v;
    return r;
  endfunction

  // Element (r,k) = r+1 for a 4x4 operand
  function automatic logic [127:0] rows8();
    logic [127:0] r;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) r[(i*4+k)*8 +: 8] = 8'(i + 1);
    return r;
  endfunction

  function automatic logic [511:0] fill32(input logic [31:0] v);
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = v;
    return r;
  endfunction

  function automatic logic [255:0] fill16(input logic [15:0] v);
    logic [255:0] r;
    for (int i = 0; i < 16; i++) r[i*16 +: 16] = v;
    return r;
  endfunction

  // Offer one op to the default instance and hold it across one edge.
  task automatic accept1(input logic [127:0] a, input logic [127:0] b, input logic [511:0] c,
                         input logic chain, input logic [15:0] md);
    in_a = a; in_b = b; in_c = c; in_chain = chain; in_mdata = md; in_valid = 1'b1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL accept_ready: in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_chain = 1'b0;
  endtask

  task automatic accept_w(input logic [127:0] a, input logic [127:0] b, input logic [255:0] c,
                          input logic [15:0] md);
    w_in_a = a; w_in_b = b; w_in_c = c; w_in_chain = 1'b0; w_in_mdata = md; w_in_valid = 1'b1;
    n_cmp++;
    if (w_in_ready !== 1'b1) begin
      n_bad++; $display("FAIL w_accept_ready: in_ready=%b required 1", w_in_ready);
    end
    @(posedge clk); #1;
    w_in_valid = 1'b0;
  endtask

  // Cycle 1 is the cycle right after the accepting edge; returns the cycle where out_valid is seen.
  task automatic wait_out1(output int cyc);
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 60) begin @(posedge clk); #1; cyc++; end
  endtask

  task automatic wait_out_w(output int cyc);
    cyc = 1;
    while (w_out_valid !== 1'b1 && cyc < 60) begin @(posedge clk); #1; cyc++; end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0; in_chain = 1'b0; in_a = '0; in_b = '0; in_c = '0; in_mdata = '0;
    out_ready = 1'b1;
    w_in_valid = 1'b0; w_in_chain = 1'b0; w_in_a = '0; w_in_b = '0; w_in_c = '0;
    w_in_mdata = '0; w_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: %b required 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: %b required 1", in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: %b required 0", busy); end
    n_cmp++; if (out_d !== 512'd0) begin n_bad++; $display("FAIL rst_out_d: %h required 0", out_d); end
    n_cmp++; if (out_mdata !== 16'd0) begin n_bad++; $display("FAIL rst_mdata: %h required 0", out_mdata); end
    n_cmp++; if (w_in_ready !== 1'b1 || w_out_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_w: in_ready=%b out_valid=%b required 1/0", w_in_ready, w_out_valid);
    end
  endtask

  task automatic test_ones();
    int cyc;
    accept1(fill8(8'd1), fill8(8'd2), fill32(32'd5), 1'b0, 16'hA001);
    n_cmp++; if (busy !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL ones_issue: busy=%b out_valid=%b required 1/0", busy, out_valid);
    end
    wait_out1(cyc);
    n_cmp++; if (cyc !== 8) begin n_bad++; $display("FAIL ones_latency: %0d required 8", cyc); end
    n_cmp++; if (out_mdata !== 16'hA001) begin n_bad++; $display("FAIL ones_mdata: %h required a001", out_mdata); end
    for (int e = 0; e < 16; e++) begin
      n_cmp++;
      if (out_d[e*32 +: 32] !== 32'd13) begin
        n_bad++; $display("FAIL ones_d[%0d]: %0d required 13", e, out_d[e*32 +: 32]);
      end
    end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL ones_idle: out_valid=%b busy=%b required 0/0", out_valid, busy);
    end
  endtask

  task automatic test_pattern();
    int cyc;
    accept1(rows8(), rows8(), fill32(32'd0), 1'b0, 16'h0002);
    wait_out1(cyc);
    n_cmp++; if (cyc !== 8) begin n_bad++; $display("FAIL pat_latency: %0d required 8", cyc); end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        n_cmp++;
        if (out_d[(i*4+j)*32 +: 32] !== 32'(4*(i+1)*(j+1))) begin
          n_bad++; $display("FAIL pat_d(%0d,%0d): %0d required %0d", i, j,
                            out_d[(i*4+j)*32 +: 32], 4*(i+1)*(j+1));
        end
      end
    @(posedge clk); #1;
  endtask

  task automatic test_chain();
    int cyc;
    accept1(fill8(8'd1), fill8(8'd1), fill32(32'd0), 1'b0, 16'h0003);
    wait_out1(cyc);
    n_cmp++; if (out_d !== fill32(32'd4)) begin n_bad++; $display("FAIL chain_op1: %h required all 4", out_d); end
    @(posedge clk); #1;
    accept1(fill8(8'd1), fill8(8'd1), fill32(32'h0000DEAD), 1'b1, 16'h0004);
    wait_out1(cyc);
    n_cmp++; if (cyc !== 8) begin n_bad++; $display("FAIL chain_latency: %0d required 8", cyc); end
    for (int e = 0; e < 16; e++) begin
      n_cmp++;
      if (out_d[e*32 +: 32] !== 32'd8) begin
        n_bad++; $display("FAIL chain_d[%0d]: %0d required 8", e, out_d[e*32 +: 32]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [511:0] d_snap;
    out_ready = 1'b0;
    accept1(fill8(8'd1), fill8(8'd1), fill32(32'd0), 1'b0, 16'hBEEF);
    wait_out1(cyc);
    d_snap = out_d;
    n_cmp++; if (d_snap !== fill32(32'd4)) begin n_bad++; $display("FAIL bp_d: %h required all 4", d_snap); end
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_d !== d_snap || out_mdata !== 16'hBEEF) begin
        n_bad++; $display("FAIL bp_hold cyc %0d: out_valid=%b mdata=%h required 1/beef, d stable", n, out_valid, out_mdata);
      end
      n_cmp++;
      if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready cyc %0d: %b required 0", n, in_ready); end
    end
    in_a = fill8(8'd2); in_b = fill8(8'd1); in_c = fill32(32'd1); in_mdata = 16'hC0DE;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready: %b required 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++; if (busy !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL b2b_issue: busy=%b out_valid=%b required 1/0", busy, out_valid);
    end
    wait_out1(cyc);
    n_cmp++; if (cyc !== 8) begin n_bad++; $display("FAIL b2b_latency: %0d required 8", cyc); end
    n_cmp++; if (out_d !== fill32(32'd9) || out_mdata !== 16'hC0DE) begin
      n_bad++; $display("FAIL b2b_result: d=%h mdata=%h required all 9 / c0de", out_d, out_mdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit seen;
    accept1(fill8(8'd1), fill8(8'd1), fill32(32'd0), 1'b0, 16'h1111);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL rmid_state: in_ready=%b busy=%b out_valid=%b required 1/0/0", in_ready, busy, out_valid);
    end
    n_cmp++; if (out_d !== 512'd0) begin n_bad++; $display("FAIL rmid_buf: %h required 0", out_d); end
    seen = 1'b0;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rmid_no_out: out_valid seen=1 required 0"); end
    accept1(fill8(8'd1), fill8(8'd1), fill32(32'h0000DEAD), 1'b1, 16'h2222);
    wait_out1(cyc);
    n_cmp++; if (cyc !== 8) begin n_bad++; $display("FAIL rmid_latency: %0d required 8", cyc); end
    n_cmp++; if (out_d !== fill32(32'd4) || out_mdata !== 16'h2222) begin
      n_bad++; $display("FAIL rmid_chain: d=%h mdata=%h required all 4 / 2222", out_d, out_mdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_lanes2_pattern();
    int cyc;
    accept_w(rows8(), rows8(), fill16(16'd0), 16'h0055);
    wait_out_w(cyc);
    n_cmp++; if (cyc !== 12) begin n_bad++; $display("FAIL w_pat_latency: %0d required 12", cyc); end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        n_cmp++;
        if (w_out_d[(i*4+j)*16 +: 16] !== 16'(4*(i+1)*(j+1))) begin
          n_bad++; $display("FAIL w_pat_d(%0d,%0d): %0d required %0d", i, j,
                            w_out_d[(i*4+j)*16 +: 16], 4*(i+1)*(j+1));
        end
      end
    n_cmp++; if (w_out_mdata !== 16'h0055) begin n_bad++; $display("FAIL w_pat_mdata: %h required 0055", w_out_mdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    int cyc;
    accept_w(fill8(8'h80), fill8(8'h80), fill16(16'h7FFF), 16'h0066);
    wait_out_w(cyc);
    n_cmp++; if (w_out_d !== fill16(16'h7FFF)) begin n_bad++; $display("FAIL wrap_pos: %h required all 7fff", w_out_d); end
    @(posedge clk); #1;
    accept_w(fill8(8'h7F), fill8(8'h80), fill16(16'h7FFF), 16'h0077);
    wait_out_w(cyc);
    n_cmp++; if (cyc !== 12) begin n_bad++; $display("FAIL wrap_latency: %0d required 12", cyc); end
    n_cmp++; if (w_out_d !== fill16(16'h81FF)) begin n_bad++; $display("FAIL wrap_neg: %h required all 81ff", w_out_d); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_ones();
    test_pattern();
    test_chain();
    test_back_to_back();
    test_reset_mid();
    test_lanes2_pattern();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
